// File: rtl/hog_block_sum.sv
// -----------------------------------------------------------------------------
// hog_block_sum
//   Energy accumulator for groups of four 3x3 HOG blocks. Each accepted group
//   flows through a two-stage adder pipeline (row sums, then block sums). The
//   four 24-bit block sums and their row/column tags are buffered in a small
//   result FIFO. A running per-frame maximum and an end-of-frame pulse are
//   derived from the stage-2 results.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   valid, cnt_row, cnt_col     upstream group strobe and its tags (no stall)
//   block_out_0..3 [179:0]      nine unsigned 20-bit elements per block,
//                               element k at bits [20k+19:20k]
//   out_valid / out_ready       FIFO head handshake
//   out_sum_0..3, out_row/col   head entry (zero while the FIFO is empty)
//   frame_max                   largest block sum in the current/last frame
//   frame_done                  one-cycle pulse after the last group of a frame
//   overflow                    sticky: a result was dropped on a full FIFO
// -----------------------------------------------------------------------------
module hog_block_sum #(
  parameter int FIFO_DEPTH = 4,
  parameter int LAST_ROW   = 159,
  parameter int LAST_COL   = 52
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid,
  input  logic [7:0]   cnt_row,
  input  logic [5:0]   cnt_col,
  input  logic [179:0] block_out_0,
  input  logic [179:0] block_out_1,
  input  logic [179:0] block_out_2,
  input  logic [179:0] block_out_3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [23:0]  out_sum_0,
  output logic [23:0]  out_sum_1,
  output logic [23:0]  out_sum_2,
  output logic [23:0]  out_sum_3,
  output logic [7:0]   out_row,
  output logic [5:0]   out_col,
  output logic [23:0]  frame_max,
  output logic         frame_done,
  output logic         overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [3:0][23:0] sum;
    logic [7:0]       row;
    logic [5:0]       col;
  } entry_t;

  logic [179:0] blk [4];
  assign blk[0] = block_out_0;
  assign blk[1] = block_out_1;
  assign blk[2] = block_out_2;
  assign blk[3] = block_out_3;

  // Stage 1: three row sums per block (row r covers elements 3r+2..3r).
  logic        s1_valid_q;
  logic [7:0]  s1_row_q;
  logic [5:0]  s1_col_q;
  logic [21:0] s1_rs_d [4][3];
  logic [21:0] s1_rs_q [4][3];

  // Stage 2: full block sums.
  logic             s2_valid_q;
  logic [7:0]       s2_row_q;
  logic [5:0]       s2_col_q;
  logic [3:0][23:0] s2_sum_d;
  logic [3:0][23:0] s2_sum_q;

  // NOTE: every always_comb variable gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    s1_rs_d  = '{default: '0};
    s2_sum_d = '0;
    for (int b = 0; b < 4; b++) begin
      for (int r = 0; r < 3; r++) begin
        s1_rs_d[b][r] = 22'(blk[b][20*(3*r)   +: 20])
                      + 22'(blk[b][20*(3*r+1) +: 20])
                      + 22'(blk[b][20*(3*r+2) +: 20]);
      end
      s2_sum_d[b] = 24'(s1_rs_q[b][0]) + 24'(s1_rs_q[b][1]) + 24'(s1_rs_q[b][2]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= valid;
      s2_valid_q <= s1_valid_q;
    end
  end

  // Datapath registers carry no reset: they are only observed behind a valid.
  always_ff @(posedge clk) begin
    s1_row_q <= cnt_row;
    s1_col_q <= cnt_col;
    s1_rs_q  <= s1_rs_d;
    s2_row_q <= s1_row_q;
    s2_col_q <= s1_col_q;
    s2_sum_q <= s2_sum_d;
  end

  // Result FIFO. A push while full is accepted only if the head leaves in the
  // same cycle; the write then lands in the slot being vacated.
  entry_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          full, pop, wr_en;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign wr_en     = s2_valid_q && (!full || pop);

  // NOTE: the FIFO storage is not reset; the pointers and count define which
  // entries are live, and the head outputs are gated while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{sum: s2_sum_q, row: s2_row_q, col: s2_col_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
      if (wr_en && !pop)      count_q <= count_q + 1'b1;
      else if (!wr_en && pop) count_q <= count_q - 1'b1;
      if (s2_valid_q && full && !pop) overflow <= 1'b1;
    end
  end

  entry_t head;
  assign head      = mem_q[rd_ptr_q];
  assign out_sum_0 = out_valid ? head.sum[0] : '0;
  assign out_sum_1 = out_valid ? head.sum[1] : '0;
  assign out_sum_2 = out_valid ? head.sum[2] : '0;
  assign out_sum_3 = out_valid ? head.sum[3] : '0;
  assign out_row   = out_valid ? head.row    : '0;
  assign out_col   = out_valid ? head.col    : '0;

  // Frame statistics, updated from every stage-2 result (dropped or not).
  // A (0,0) tag restarts the maximum for a new frame.
  logic [23:0] grp_max, max_01, max_23, fmax_d;
  logic        done_d;

  always_comb begin
    max_01  = (s2_sum_q[0] > s2_sum_q[1]) ? s2_sum_q[0] : s2_sum_q[1];
    max_23  = (s2_sum_q[2] > s2_sum_q[3]) ? s2_sum_q[2] : s2_sum_q[3];
    grp_max = (max_01 > max_23) ? max_01 : max_23;
    fmax_d  = frame_max;
    done_d  = 1'b0;
    if (s2_valid_q) begin
      if (s2_row_q == '0 && s2_col_q == '0) fmax_d = grp_max;
      else if (grp_max > frame_max)         fmax_d = grp_max;
      done_d = (s2_row_q == 8'(LAST_ROW)) && (s2_col_q == 6'(LAST_COL));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_max  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_max  <= fmax_d;
      frame_done <= done_d;
    end
  end

endmodule
